// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
// The optional DCACHE_STATS_EN build macro is consumed by dcache_responder.
package cache_pkg;

  localparam int DEF_SETS   = 16;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_IDXW   = $clog2(DEF_SETS);
  localparam int DEF_TAGW   = DEF_WORD_W - DEF_IDXW - 2;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    FLUSH,
    DONE
  } dcache_state_t;

  // One cache frame at the default geometry.
  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [DEF_TAGW-1:0] tag;
    logic [DEF_WORD_W-1:0] data;
  } dframe_t;

endpackage

// File: rtl/dcache_frame_array.sv
// Frame storage: valid/dirty bits with asynchronous reset, tag/data without reset.
// One combinational read port and one synchronous write port.
module dcache_frame_array #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [$clog2(SETS)-1:0]             rd_idx,
  output logic                                rd_valid,
  output logic                                rd_dirty,
  output logic [WORD_W-$clog2(SETS)-3:0]      rd_tag,
  output logic [WORD_W-1:0]                   rd_data,
  input  logic                                wr_en,
  input  logic [$clog2(SETS)-1:0]             wr_idx,
  input  logic                                wr_valid,
  input  logic                                wr_dirty,
  input  logic [WORD_W-$clog2(SETS)-3:0]      wr_tag,
  input  logic [WORD_W-1:0]                   wr_data
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = WORD_W - IDXW - 2;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [WORD_W-1:0] data_q [SETS];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data are only meaningful once valid is set, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate one-word-block data cache with halt flush.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise they read 0.
module dcache_responder
  import cache_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                halt,
  input  logic                dmemREN,
  input  logic                dmemWEN,
  input  logic [WORD_W-1:0]   dmemaddr,
  input  logic [WORD_W-1:0]   dmemstore,
  output logic [WORD_W-1:0]   dmemload,
  output logic                dhit,
  output logic                flushed,
  output logic                dREN,
  output logic                dWEN,
  output logic [WORD_W-1:0]   daddr,
  output logic [WORD_W-1:0]   dstore,
  input  logic [WORD_W-1:0]   dload,
  input  logic                dwait,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output dcache_state_t       dbg_state
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = WORD_W - IDXW - 2;

  // Handshake: a processor request (dmemREN/dmemWEN with a stable dmemaddr) is
  // serviced in the single cycle dhit=1; a memory transfer (dREN or dWEN held
  // with a stable daddr) completes in the first cycle dwait=0.

  dcache_state_t   state_q, state_d;
  logic [IDXW-1:0] fidx_q, fidx_d;

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic            unused_addr_bits;

  logic [IDXW-1:0]   rd_idx;
  logic              rd_valid, rd_dirty;
  logic [TAGW-1:0]   rd_tag;
  logic [WORD_W-1:0] rd_data;

  logic              wr_en, wr_valid, wr_dirty;
  logic [IDXW-1:0]   wr_idx;
  logic [TAGW-1:0]   wr_tag;
  logic [WORD_W-1:0] wr_data;

  logic hit, victim_dirty;

  assign req_idx          = dmemaddr[IDXW+1:2];
  assign req_tag          = dmemaddr[WORD_W-1:IDXW+2];
  assign unused_addr_bits = ^dmemaddr[1:0];

  // The single read port follows the flush pointer while flushing.
  assign rd_idx       = (state_q == FLUSH) ? fidx_q : req_idx;
  assign hit          = rd_valid && (rd_tag == req_tag);
  assign victim_dirty = rd_valid && rd_dirty;

  dcache_frame_array #(
    .SETS   (SETS),
    .WORD_W (WORD_W)
  ) u_frames (
    .CLK      (CLK),
    .RST      (RST),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fidx_d   = fidx_q;
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    wr_en    = 1'b0;
    wr_idx   = req_idx;
    wr_valid = 1'b0;
    wr_dirty = 1'b0;
    wr_tag   = req_tag;
    wr_data  = dmemstore;
    case (state_q)
      IDLE: begin
        // halt takes priority over any pending request.
        if (halt) begin
          state_d = FLUSH;
          fidx_d  = '0;
        end else if (dmemREN || dmemWEN) begin
          if (hit) begin
            dhit = 1'b1;
            if (dmemWEN) begin
              wr_en    = 1'b1;
              wr_valid = 1'b1;
              wr_dirty = 1'b1;
            end else begin
              dmemload = rd_data;
            end
          end else begin
            state_d = victim_dirty ? WB : FILL;
          end
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {rd_tag, req_idx, 2'b00};
        dstore = rd_data;
        if (!dwait) state_d = FILL;
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[WORD_W-1:2], 2'b00};
        if (!dwait) begin
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_data  = dload;
          state_d  = IDLE;
        end
      end
      FLUSH: begin
        wr_idx = fidx_q;
        if (victim_dirty) begin
          dWEN   = 1'b1;
          daddr  = {rd_tag, fidx_q, 2'b00};
          dstore = rd_data;
        end
        // Clean frames advance immediately; dirty ones wait for the write.
        if (!victim_dirty || !dwait) begin
          if (victim_dirty) begin
            wr_en    = 1'b1;
            wr_valid = 1'b1;
            wr_dirty = 1'b0;
            wr_tag   = rd_tag;
            wr_data  = rd_data;
          end
          fidx_d = fidx_q + IDXW'(1);
          if (fidx_q == IDXW'(SETS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign flushed   = (state_q == DONE);
  assign dbg_state = state_q;

`ifdef DCACHE_STATS_EN
  logic        hit_evt, miss_evt;
  logic [31:0] hit_q, miss_q;

  assign hit_evt  = dhit;
  assign miss_evt = (state_q == IDLE) && ((state_d == WB) || (state_d == FILL));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_evt)  hit_q  <= hit_q + 32'd1;
      if (miss_evt) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: randomized requests checked against a
// last-written-value memory model; memory write traffic checked against a writeback queue.
module tb_dcache_responder;
  import cache_pkg::*;

  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        halt, dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait;
  logic [31:0] hit_count, miss_count;
  dcache_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  dcache_responder dut (
    .CLK        (CLK),
    .RST        (RST),
    .halt       (halt),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .dmemaddr   (dmemaddr),
    .dmemstore  (dmemstore),
    .dmemload   (dmemload),
    .dhit       (dhit),
    .flushed    (flushed),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .daddr      (daddr),
    .dstore     (dstore),
    .dload      (dload),
    .dwait      (dwait),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] mem [logic [31:0]];
  int lat_fixed = 0;
  int busy_cnt  = 0;
  int rd_cycles = 0;
  int wr_done   = 0;
  logic [31:0] last_fill_addr = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic int pick_lat();
    return (lat_fixed < 0) ? int'($urandom_range(3, 0)) : lat_fixed;
  endfunction

  task automatic set_lat(input int l);
    lat_fixed = l;
    busy_cnt  = pick_lat();
  endtask

  // ---------------- reference model ----------------
  logic        mvalid [SETS];
  logic        mdirty [SETS];
  logic [25:0] mtag   [SETS];
  logic [31:0] truth  [logic [31:0]];
  int          m_hits, m_miss;
  logic [31:0] exp_q [$];
  logic [63:0] wb_q  [$];

  function automatic logic [31:0] truth_read(input logic [31:0] a);
    return truth.exists(a) ? truth[a] : mem_read(a);
  endfunction

  task automatic model_access(input logic [31:0] a, input bit wen, input logic [31:0] d, input bit push);
    logic [3:0]  s;
    logic [25:0] t;
    logic [31:0] wa, va;
    s  = a[5:2];
    t  = a[31:6];
    wa = {a[31:2], 2'b00};
    if (!(mvalid[s] && mtag[s] == t)) begin
      m_miss++;
      if (mvalid[s] && mdirty[s]) begin
        va = {mtag[s], s, 2'b00};
        wb_q.push_back({va, truth_read(va)});
      end
      mvalid[s] = 1'b1;
      mtag[s]   = t;
      mdirty[s] = 1'b0;
    end
    if (push) begin
      m_hits++;
      if (wen) begin
        truth[wa] = d;
        mdirty[s] = 1'b1;
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(truth_read(wa));
      end
    end
  endtask

  task automatic model_flush();
    logic [31:0] va;
    for (int s = 0; s < SETS; s++) begin
      if (mvalid[s] && mdirty[s]) begin
        va = {mtag[s], 4'(s), 2'b00};
        wb_q.push_back({va, truth_read(va)});
        mdirty[s] = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mvalid[s] = 1'b0;
      mdirty[s] = 1'b0;
      mtag[s]   = '0;
    end
    truth.delete();
    exp_q.delete();
    wb_q.delete();
    m_hits = 0;
    m_miss = 0;
  endtask

  // ---------------- memory responder + writeback checker ----------------
  always @(negedge CLK) begin
    logic [63:0] e;
    if (RST) begin
      dwait = 1'b0;
    end else if (dREN || dWEN) begin
      if (busy_cnt > 0) begin
        dwait = 1'b1;
        busy_cnt--;
      end else begin
        dwait = 1'b0;
      end
      dload = dREN ? mem_read(daddr) : 32'h0;
      if (dREN) begin
        rd_cycles++;
        last_fill_addr = daddr;
      end
      if (!dwait) begin
        if (dWEN) begin
          wr_done++;
          if (wb_q.size() == 0) begin
            fail_now("unexpected_mem_write");
          end else begin
            e = wb_q.pop_front();
            check("wb_addr", daddr, e[63:32]);
            check("wb_data", dstore, e[31:0]);
          end
          mem[daddr] = dstore;
        end
        busy_cnt = pick_lat();
      end
    end else begin
      dwait = 1'b0;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge CLK) begin
    if (!RST && dhit) begin
      if (exp_q.size() == 0) fail_now("unexpected_dhit");
      else check("dmemload", dmemload, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input bit wen, input logic [31:0] d, input bit push);
    model_access(a, wen, d, push);
    dmemaddr  = a;
    dmemWEN   = wen;
    dmemREN   = wen ? 1'($urandom_range(1, 0)) : 1'b1;
    dmemstore = d;
  endtask

  task automatic wait_hit(input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!dhit && n < 300);
    if (!dhit) fail_now({name, "_timeout"});
  endtask

  task automatic release_req();
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input bit wen, input logic [31:0] d);
    issue(a, wen, d, 1'b1);
    wait_hit("access");
    release_req();
  endtask

  task automatic do_reset();
    RST     = 1'b1;
    halt    = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    set_lat(0);
  endtask

  task automatic wait_flushed(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!flushed && n < 100);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd0, wr0, n;
    logic [31:0] a;
    RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = '0; dmemstore = '0; dload = '0; dwait = 1'b0;
    model_reset();
    #2;
    check("rst_dhit", 32'(dhit), 0);
    check("rst_flushed", 32'(flushed), 0);
    check("rst_dREN", 32'(dREN), 0);
    check("rst_dWEN", 32'(dWEN), 0);
    check("rst_daddr", daddr, 0);
    check("rst_dstore", dstore, 0);
    check("rst_dmemload", dmemload, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Cold read with three busy cycles.
    mem[32'h40] = 32'hDEAD_BEEF;
    set_lat(3);
    rd0 = rd_cycles;
    access(32'h40, 1'b0, 0);
    check("cold_fill_cycles", 32'(rd_cycles - rd0), 4);
    check("cold_fill_addr", last_fill_addr, 32'h40);
    set_lat(0);
    repeat (3) access(32'h40, 1'b0, 0);
`ifdef DCACHE_STATS_EN
    check("stats_hits", hit_count, 4);
    check("stats_miss", miss_count, 1);
`else
    check("stats_hits_off", hit_count, 0);
    check("stats_miss_off", miss_count, 0);
`endif

    // Dirty victim eviction.
    access(32'h40, 1'b1, 32'h1234_5678);
    access(32'h440, 1'b0, 0);
    check("evict_fill_addr", last_fill_addr, 32'h440);
    check("evict_wb_drained", 32'(wb_q.size()), 0);

    // Randomized traffic over a small conflicting footprint.
    set_lat(-1);
    for (int i = 0; i < 400; i++) begin
      a = (32'($urandom_range(3, 0)) << 6) | (32'($urandom_range(15, 0)) << 2) | 32'($urandom_range(3, 0));
      access(a, 1'($urandom_range(1, 0)), $urandom);
    end
`ifdef DCACHE_STATS_EN
    check("rand_hits", hit_count, 32'(m_hits));
    check("rand_miss", miss_count, 32'(m_miss));
`endif
    check("rand_exp_drained", 32'(exp_q.size()), 0);

    // Flush of dirty frames at idx 0, 3, 15.
    do_reset();
    access(32'h140, 1'b1, 32'h0000_AAAA);
    access(32'h14C, 1'b1, 32'h0000_BBBB);
    access(32'h17C, 1'b1, 32'h0000_CCCC);
    access(32'h15C, 1'b0, 0);
    model_flush();
    wr0  = wr_done;
    halt = 1'b1;
    wait_flushed(n);
    check("flush_cycles", 32'(n), 18);
    check("flush_writes", 32'(wr_done - wr0), 3);
    check("flush_state", 32'(dbg_state), 32'(DONE));
    @(posedge CLK); #1;
    dmemaddr = 32'h140; dmemREN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      halt = 1'($urandom_range(1, 0));
      @(negedge CLK);
      check("done_sticky", {28'h0, flushed, dhit, dREN, dWEN}, 32'h8);
    end
    dmemREN = 1'b0; halt = 1'b0;

    // halt arriving mid-FILL after a dirty writeback.
    do_reset();
    access(32'h54, 1'b1, 32'hCAFE_F00D);
    set_lat(3);
    rd0 = rd_cycles;
    wr0 = wr_done;
    issue(32'hD4, 1'b0, 0, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!dREN && n < 50);
    check("midfill_reached", 32'(dREN), 1);
    @(posedge CLK); #1;
    halt = 1'b1;
    model_flush();
    wait_flushed(n);
    check("midfill_flushed", 32'(flushed), 1);
    check("midfill_fill_cycles", 32'(rd_cycles - rd0), 4);
    check("midfill_writes", 32'(wr_done - wr0), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      halt = ~halt;
      @(negedge CLK);
      check("midfill_sticky", 32'(flushed), 1);
    end
    dmemREN = 1'b0; halt = 1'b0;

    // Reset while a writeback is stalled.
    do_reset();
    access(32'h40, 1'b1, 32'hA1B2_C3D4);
    set_lat(50);
    issue(32'h440, 1'b0, 0, 1'b1);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!dWEN && n < 20);
    check("wb_started", 32'(dWEN), 1);
    #2 RST = 1'b1;
    #1;
    check("wb_abort_dWEN", 32'(dWEN), 0);
    check("wb_abort_dREN", 32'(dREN), 0);
    dmemREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    set_lat(0);
    rd0 = rd_cycles;
    access(32'h40, 1'b0, 0);
    check("post_rst_miss", 32'(rd_cycles - rd0), 1);
`ifdef DCACHE_STATS_EN
    check("post_rst_hits", hit_count, 1);
    check("post_rst_miss_cnt", miss_count, 1);
`else
    check("post_rst_hits_off", hit_count, 0);
`endif

    repeat (3) @(negedge CLK);
    check("final_exp_q", 32'(exp_q.size()), 0);
    check("final_wb_q", 32'(wb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
